pipelined_adder_sub: RTL and testbench

//  Parametrised, pipelined two's-complement adder/subtractor with signed-overflow flags,

---
 rtl/pipelined_adder_sub.sv | 182 ++++++++++++++++++
 tb/tb_pipelined_adder_sub.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement adder/subtractor: one carry chunk per stage, signed-overflow
// flags, optional saturation and a global-enable valid/ready handshake.
module pipelined_adder_sub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4,
  parameter bit          SAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             pos_ovf,
  output logic             neg_ovf,
  output logic             zero
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             pos_ovf_d, pos_ovf_q;
  logic             neg_ovf_d, neg_ovf_q;
  logic             zero_d, zero_q;

  always_comb begin
    adv   = !out_valid_q || out_ready;
    b_eff = sub ? ~b : b;
    c_eff = cin ^ sub;
  end

  assign in_ready = adv;

  // Operands entering the last chunk, from the ports or the last intermediate stage
  logic [WIDTH-1:0] fin_x;
  logic [CHUNK-1:0] fin_y;
  logic             fin_c;
  logic             fin_v;

  // Intermediate stages: x carries finished sum chunks plus untouched A bits,
  // y carries only the B chunks not yet consumed, so it narrows every stage.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_pipe
    localparam int unsigned YI = WIDTH - k * CHUNK;
    localparam int unsigned YO = YI - CHUNK;

    logic [WIDTH-1:0] x_i, x_d, x_q;
    logic [YI-1:0]    y_i;
    logic [YO-1:0]    y_d, y_q;
    logic             c_i, c_d, c_q;
    logic             v_i, v_d, v_q;
    logic [CHUNK:0]   part;

    if (k == 0) begin : g_src
      assign x_i = a;
      assign y_i = b_eff;
      assign c_i = c_eff;
      assign v_i = in_valid;
    end else begin : g_src
      assign x_i = g_pipe[k-1].x_q;
      assign y_i = g_pipe[k-1].y_q;
      assign c_i = g_pipe[k-1].c_q;
      assign v_i = g_pipe[k-1].v_q;
    end

    always_comb begin
      part = {1'b0, x_i[k*CHUNK +: CHUNK]} + {1'b0, y_i[CHUNK-1:0]} + (CHUNK+1)'(c_i);
      x_d  = x_q;
      y_d  = y_q;
      c_d  = c_q;
      v_d  = v_q;
      if (adv) begin
        x_d                   = x_i;
        x_d[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        y_d                   = y_i[YI-1:CHUNK];
        c_d                   = part[CHUNK];
        v_d                   = v_i;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_q <= '0;
        y_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else begin
        x_q <= x_d;
        y_q <= y_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end
  end

  if (STAGES == 1) begin : g_fin_src
    assign fin_x = a;
    assign fin_y = b_eff;
    assign fin_c = c_eff;
    assign fin_v = in_valid;
  end else begin : g_fin_src
    assign fin_x = g_pipe[STAGES-2].x_q;
    assign fin_y = g_pipe[STAGES-2].y_q;
    assign fin_c = g_pipe[STAGES-2].c_q;
    assign fin_v = g_pipe[STAGES-2].v_q;
  end

  logic [CHUNK:0]   fin_part;
  logic [WIDTH-1:0] raw_lo;
  logic             as_bit, bs_bit, ovf, pos_c, neg_c;

  // Top chunk, flags and saturation; fin_x[WIDTH-1] is still the A sign bit here
  always_comb begin
    fin_part = {1'b0, fin_x[WIDTH-1 -: CHUNK]} + {1'b0, fin_y} + (CHUNK+1)'(fin_c);
    raw_lo   = fin_x;
    raw_lo[WIDTH-1 -: CHUNK] = fin_part[CHUNK-1:0];
    as_bit   = fin_x[WIDTH-1];
    bs_bit   = fin_y[CHUNK-1];
    ovf      = (as_bit == bs_bit) && (raw_lo[WIDTH-1] != as_bit);
    pos_c    = ovf && !as_bit;
    neg_c    = ovf && as_bit;

    out_valid_d = out_valid_q;
    s_d         = s_q;
    cout_d      = cout_q;
    pos_ovf_d   = pos_ovf_q;
    neg_ovf_d   = neg_ovf_q;
    zero_d      = zero_q;
    if (adv) begin
      out_valid_d = fin_v;
      s_d         = raw_lo;
      if (SAT && pos_c) begin
        s_d = MAX_POS;
      end else if (SAT && neg_c) begin
        s_d = MIN_NEG;
      end
      cout_d    = fin_part[CHUNK];
      pos_ovf_d = pos_c;
      neg_ovf_d = neg_c;
      zero_d    = (raw_lo == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      pos_ovf_q   <= 1'b0;
      neg_ovf_q   <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      pos_ovf_q   <= pos_ovf_d;
      neg_ovf_q   <= neg_ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign pos_ovf   = pos_ovf_q;
  assign neg_ovf   = neg_ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Directed bench for pipelined_adder_sub: four instances (S4 wrap, S4 sat, S1 wrap, S8 sat)
// sharing operand buses; each directed step drives one instance at a time.
module tb_pipelined_adder_sub;

  localparam int unsigned W  = 32;
  localparam int          ND = 4;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] a, b;
  logic cin, sub;
  logic [ND-1:0] in_valid_i, out_ready_i;
  logic [ND-1:0] in_ready_o, out_valid_o, cout_o, pos_o, neg_o, zero_o;
  logic [ND-1:0][W-1:0] s_o;

  int checks = 0;
  int errors = 0;
  int lat_tab [ND] = '{4, 4, 1, 8};
  bit sat_tab [ND] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic [W-1:0] sv_a   [8] = '{32'h12345678, 32'h7FFFFFFF, 32'h80000000, 32'h00000000,
                               32'hFFFFFFFF, 32'hDEADBEEF, 32'h0000000A, 32'h80000000};
  logic [W-1:0] sv_b   [8] = '{32'h9ABCDEF0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000,
                               32'h00000001, 32'hDEADBEEF, 32'h00000003, 32'h80000000};
  logic         sv_cin [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic         sv_sub [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  pipelined_adder_sub #(.WIDTH(W), .STAGES(4), .SAT(1'b0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid_o[0]), .out_ready(out_ready_i[0]), .s(s_o[0]),
    .cout(cout_o[0]), .pos_ovf(pos_o[0]), .neg_ovf(neg_o[0]), .zero(zero_o[0]));
  pipelined_adder_sub #(.WIDTH(W), .STAGES(4), .SAT(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid_o[1]), .out_ready(out_ready_i[1]), .s(s_o[1]),
    .cout(cout_o[1]), .pos_ovf(pos_o[1]), .neg_ovf(neg_o[1]), .zero(zero_o[1]));
  pipelined_adder_sub #(.WIDTH(W), .STAGES(1), .SAT(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_i[2]), .in_ready(in_ready_o[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid_o[2]), .out_ready(out_ready_i[2]), .s(s_o[2]),
    .cout(cout_o[2]), .pos_ovf(pos_o[2]), .neg_ovf(neg_o[2]), .zero(zero_o[2]));
  pipelined_adder_sub #(.WIDTH(W), .STAGES(8), .SAT(1'b1)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid_i[3]), .in_ready(in_ready_o[3]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid_o[3]), .out_ready(out_ready_i[3]), .s(s_o[3]),
    .cout(cout_o[3]), .pos_ovf(pos_o[3]), .neg_ovf(neg_o[3]), .zero(zero_o[3]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference built from the true signed value, independent of the sign-bit rule
  function automatic logic [W+3:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic su, input bit sat);
    logic [W:0]   raw;
    longint       ta, tb, tt;
    logic         p, n;
    logic [W-1:0] sv;
    raw = {1'b0, av} + {1'b0, (su ? ~bv : bv)} + (W+1)'(ci ^ su);
    ta  = longint'($signed(av));
    tb  = longint'($signed(bv));
    tt  = su ? (ta - tb - longint'(ci)) : (ta + tb + longint'(ci));
    p   = (tt > 64'sd2147483647);
    n   = (tt < -64'sd2147483648);
    sv  = raw[W-1:0];
    if (sat && p) sv = 32'h7FFFFFFF;
    else if (sat && n) sv = 32'h80000000;
    return {raw[W], p, n, (raw[W-1:0] == '0), sv};
  endfunction

  task automatic chk_idle(input int d, input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid_o[d]), 64'd0);
    chk({tag, ".in_ready"},  64'(in_ready_o[d]),  64'd1);
    chk({tag, ".s"},         64'(s_o[d]),         64'd0);
    chk({tag, ".flags"}, 64'({cout_o[d], pos_o[d], neg_o[d], zero_o[d]}), 64'd0);
  endtask

  // Single op on an empty pipe: latency counted from the cycle the operands are presented
  task automatic do_op(input int d, input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic su, input logic [W-1:0] es,
                       input logic ec, input logic ep, input logic en, input logic ez);
    int cnt;
    a = av; b = bv; cin = ci; sub = su;
    in_valid_i[d]  = 1'b1;
    out_ready_i[d] = 1'b1;
    cnt = 0;
    do begin
      step();
      cnt++;
      if (cnt == 1) in_valid_i[d] = 1'b0;
    end while (out_valid_o[d] !== 1'b1 && cnt < 40);
    chk({tag, ".latency"}, 64'(cnt), 64'(lat_tab[d]));
    chk({tag, ".s"},       64'(s_o[d]),    64'(es));
    chk({tag, ".cout"},    64'(cout_o[d]), 64'(ec));
    chk({tag, ".pos_ovf"}, 64'(pos_o[d]),  64'(ep));
    chk({tag, ".neg_ovf"}, 64'(neg_o[d]),  64'(en));
    chk({tag, ".zero"},    64'(zero_o[d]), 64'(ez));
    step();
  endtask

  // Eight back-to-back ops with out_ready toggling 1,0,1,0,...
  task automatic run_stream(input int d, input string tag);
    logic [W+3:0] expq[$];
    logic [W+3:0] obs;
    int issued, got, cyc;
    logic stalled;
    issued = 0; got = 0; cyc = 0; stalled = 1'b0;
    while (got < 8 && cyc < 200) begin
      in_valid_i[d] = (issued < 8);
      if (issued < 8) begin
        a = sv_a[issued]; b = sv_b[issued]; cin = sv_cin[issued]; sub = sv_sub[issued];
      end
      out_ready_i[d] = (cyc % 2 == 0);
      @(negedge clk);
      obs = {cout_o[d], pos_o[d], neg_o[d], zero_o[d], s_o[d]};
      if (stalled) chk({tag, ".held_valid"}, 64'(out_valid_o[d]), 64'd1);
      if (out_valid_o[d] === 1'b1) begin
        if (expq.size() == 0) chk({tag, ".unexpected"}, 64'(obs), 64'hDEAD);
        else chk({tag, ".result"}, 64'(obs), 64'(expq[0]));
        if (out_ready_i[d] && expq.size() != 0) begin
          void'(expq.pop_front());
          got++;
        end
      end
      stalled = out_valid_o[d] && !out_ready_i[d];
      if (in_valid_i[d] && in_ready_o[d]) begin
        expq.push_back(model(sv_a[issued], sv_b[issued], sv_cin[issued], sv_sub[issued], sat_tab[d]));
        issued++;
      end
      step();
      cyc++;
    end
    in_valid_i[d]  = 1'b0;
    out_ready_i[d] = 1'b1;
    chk({tag, ".count"}, 64'(got), 64'd8);
    step();
    chk({tag, ".drained"}, 64'(out_valid_o[d]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    in_valid_i = '0; out_ready_i = '1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    for (int d = 0; d < ND; d++) chk_idle(d, $sformatf("reset.d%0d", d));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    do_op(0, "addpos",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(1, "addpos_s",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(0, "addneg",    32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(1, "addneg_s",  32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(0, "carryall",  32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
    do_op(0, "carrymid",  32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(0, "sub57",     32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(0, "subborrow", 32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(0, "subneg",    32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(1, "subneg_s",  32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(1, "rawzero_s", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1);
    do_op(2, "s1carry",   32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
    do_op(3, "s8carry",   32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
    do_op(3, "s8pos_s",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill d0 with out_ready low, then reset mid-cycle with ops in flight
    a = 32'h7FFFFFFF; b = 32'h00000001; cin = 1'b0; sub = 1'b0;
    in_valid_i[0] = 1'b1; out_ready_i[0] = 1'b0;
    seen = 0;
    while (out_valid_o[0] !== 1'b1 && seen < 20) begin
      step();
      seen++;
    end
    step();
    chk("midrst.pre_valid", 64'(out_valid_o[0]), 64'd1);
    chk("midrst.pre_ready", 64'(in_ready_o[0]),  64'd0);
    chk("midrst.pre_s",     64'(s_o[0]),         64'h80000000);
    #3 rst = 1'b1;
    #1;
    chk_idle(0, "midrst");
    in_valid_i[0] = 1'b0; out_ready_i[0] = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid_o[0] !== 1'b0) seen++;
    end
    chk("midrst.no_ghosts", 64'(seen), 64'd0);

    run_stream(0, "stream_s4");
    run_stream(1, "stream_s4sat");
    run_stream(2, "stream_s1");
    run_stream(3, "stream_s8sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
